// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART transmit path: the transmit sequencer state
// encoding and the line-level constants used when framing a word.
//
// Contents:
//   tx_state_t  transmit sequencer states {IDLE, START, DATA, PARITY, STOP}
//   LINE_IDLE   level of the UART line between frames and during stop bits
//   START_BIT   level of the UART line during the start bit
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage : uart_pkg

// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
//
// Parallel-to-serial datapath driven by uart_tx_ctrl. While ser_en is sampled
// high it registers p_data[0], p_data[1], ... p_data[DWIDTH-1] onto s_data,
// one bit per clk edge, and raises ser_done together with the last bit. While
// ser_en is sampled low it holds the line level and rewinds its bit index, so
// every enabled run starts again from bit 0.
//
// Ports:
//   clk       in   bit-rate clock
//   rst       in   asynchronous, active-low reset
//   ser_en    in   enable; one bit is shifted out per edge it is sampled high
//   p_data    in   DWIDTH-bit word, held stable by the controller
//   s_data    out  registered serial bit (LINE_IDLE when disabled)
//   ser_done  out  registered; high alongside bit DWIDTH-1
// -----------------------------------------------------------------------------
module serializer
    import uart_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_en,
    input  logic [DWIDTH-1:0] p_data,
    output logic              s_data,
    output logic              ser_done
);

    localparam int IDX_W = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DWIDTH - 1);

    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            s_data   <= LINE_IDLE;
            ser_done <= 1'b0;
        end else if (ser_en) begin
            s_data   <= p_data[idx];
            ser_done <= (idx == LAST_IDX);
            idx      <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else begin
            idx      <= '0;
            s_data   <= LINE_IDLE;
            ser_done <= 1'b0;
        end
    end

endmodule : serializer

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// UART transmit sequencer. Accepts one word per frame over a valid/ready
// handshake, latches it onto p_data for the serializer, enables the serializer
// for exactly DWIDTH bit periods and frames its output with a start bit, an
// optional parity bit and STOP_BITS stop bits. One clk cycle is one bit period.
//
// Parameters:
//   DWIDTH      data bits per frame (>= 2); must match the serializer
//   PARITY_EN   1 inserts a parity bit after the data, 0 omits it
//   PARITY_ODD  0 even parity, 1 odd parity
//   STOP_BITS   number of stop bits, 1 or 2
//
// Ports:
//   clk       in   bit-rate clock
//   rst       in   asynchronous, active-low reset
//   tx_valid  in   host presents a word
//   tx_data   in   word to send, LSB first on the line
//   tx_ready  out  controller can accept a word (state IDLE)
//   p_data    out  latched word, stable for the whole frame
//   ser_en    out  registered serializer enable
//   ser_data  in   serializer s_data
//   ser_done  in   serializer ser_done
//   tx_out    out  UART line, idles high
//   busy      out  frame in progress
//   err       out  sticky serializer/controller bit-count mismatch
// -----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DWIDTH-1:0] tx_data,
    output logic              tx_ready,
    output logic [DWIDTH-1:0] p_data,
    output logic              ser_en,
    input  logic              ser_data,
    input  logic              ser_done,
    output logic              tx_out,
    output logic              busy,
    output logic              err
);

    // bit_cnt runs one past the last data bit on the exit edge, so it needs
    // room for the value DWIDTH.
    localparam int CNT_W = $clog2(DWIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DWIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DWIDTH - 2);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             stop_cnt;
    logic             parity_bit;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == IDLE) && tx_valid;
    assign last_bit = (bit_cnt == LAST_BIT);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every clocked register uses non-blocking assignment so all of them
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (tx_valid) state_next = START;
            end
            START: begin
                state_next = DATA;
            end
            DATA: begin
                // Leave on ser_done, or on the last counted bit even if the
                // serializer failed to flag it (the mismatch is recorded in err).
                if (ser_done || last_bit) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                state_next = STOP;
            end
            STOP: begin
                if (stop_cnt == LAST_STOP) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: latched word, serializer enable, counters, parity, error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_data     <= '0;
            ser_en     <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                p_data     <= tx_data;
                ser_en     <= 1'b1;
                bit_cnt    <= '0;
                stop_cnt   <= 1'b0;
                parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
            end

            if (state == DATA) begin
                bit_cnt <= bit_cnt + 1'b1;
                // ser_en was set at the accept edge and first sampled at the
                // START->DATA edge; dropping it on the edge where bit_cnt
                // becomes DWIDTH-1 leaves exactly DWIDTH sampling edges. An
                // early exit from DATA also stops the serializer.
                if (bit_cnt == PRE_LAST || state_next != DATA) begin
                    ser_en <= 1'b0;
                end
                // ser_done must coincide with the last counted bit: early done
                // or missing done are both mismatches.
                if (ser_done != last_bit) begin
                    err <= 1'b1;
                end
            end

            if (state == STOP && stop_cnt != LAST_STOP) begin
                stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: line mux over registered state, parity and serializer bit
    // -------------------------------------------------------------------------
    always_comb begin
        tx_out   = LINE_IDLE;
        tx_ready = 1'b0;
        busy     = 1'b1;
        unique case (state)
            IDLE: begin
                tx_out   = LINE_IDLE;
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            START:   tx_out = START_BIT;
            DATA:    tx_out = ser_data;
            PARITY:  tx_out = parity_bit;
            STOP:    tx_out = LINE_IDLE;
            default: begin
                tx_out   = LINE_IDLE;
                tx_ready = 1'b0;
                busy     = 1'b1;
            end
        endcase
    end

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Two controller/serializer pairs: dut_a (even parity, 1 stop bit) and dut_b
// (odd parity, 2 stop bits). Expected line bits are pushed to a queue when a
// word is driven and popped as the line is sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // dut_a: even parity, 1 stop bit
    logic          va, ready_a, sen_a, sdata_a, sdone_a, done_a, tx_a, busy_a, err_a;
    logic [DW-1:0] da, pd_a;
    // dut_b: odd parity, 2 stop bits
    logic          vb, ready_b, sen_b, sdata_b, sdone_b, tx_b, busy_b, err_b;
    logic [DW-1:0] db, pd_b;

    // early ser_done injection on dut_a
    logic inj_early, fake_done;
    assign done_a = inj_early ? fake_done : sdone_a;

    uart_tx_ctrl #(.DWIDTH(DW), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_valid(va), .tx_data(da), .tx_ready(ready_a),
        .p_data(pd_a), .ser_en(sen_a), .ser_data(sdata_a), .ser_done(done_a),
        .tx_out(tx_a), .busy(busy_a), .err(err_a)
    );
    serializer #(.DWIDTH(DW)) ser_a (
        .clk(clk), .rst(rst), .ser_en(sen_a), .p_data(pd_a),
        .s_data(sdata_a), .ser_done(sdone_a)
    );

    uart_tx_ctrl #(.DWIDTH(DW), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_valid(vb), .tx_data(db), .tx_ready(ready_b),
        .p_data(pd_b), .ser_en(sen_b), .ser_data(sdata_b), .ser_done(sdone_b),
        .tx_out(tx_b), .busy(busy_b), .err(err_b)
    );
    serializer #(.DWIDTH(DW)) ser_b (
        .clk(clk), .rst(rst), .ser_en(sen_b), .p_data(pd_b),
        .s_data(sdata_b), .ser_done(sdone_b)
    );

    // monitor view of the selected pair
    logic cur_sel;
    logic mon_tx, mon_ready, mon_busy, mon_sen;
    assign mon_tx    = cur_sel ? tx_b    : tx_a;
    assign mon_ready = cur_sel ? ready_b : ready_a;
    assign mon_busy  = cur_sel ? busy_b  : busy_a;
    assign mon_sen   = cur_sel ? sen_b   : sen_a;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    // Frame bits are written left-to-right in line order: bit (len-1) first.
    typedef struct packed {
        logic          sel;
        logic [DW-1:0] data;
        logic [4:0]    len;
        logic [15:0]   bits;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic set_in(input logic sel, input logic v, input logic [DW-1:0] d);
        if (sel) begin
            vb = v;
            db = d;
        end else begin
            va = v;
            da = d;
        end
    endtask

    task automatic push_frame(input logic [4:0] len, input logic [15:0] bits);
        for (int i = 0; i < int'(len); i++) exp_q.push_back(bits[int'(len) - 1 - i]);
    endtask

    // Waits (bounded) for tx_ready, then presents the word for one edge.
    task automatic accept(input logic sel, input logic [DW-1:0] d, input string tag);
        int t = 0;
        cur_sel = sel;
        @(negedge clk);
        while (!mon_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, " ready"}, 32'(mon_ready), 32'd1);
        set_in(sel, 1'b1, d);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, d);
    endtask

    // Pops and compares len line bits; call right after the accept edge.
    task automatic check_frame(input string tag, input int len);
        int   en_cnt = 0;
        logic want;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            want = exp_q.pop_front();
            check($sformatf("%s bit%0d", tag, i), 32'(mon_tx), 32'(want));
            check($sformatf("%s busy%0d", tag, i), 32'(mon_busy), 32'd1);
            check($sformatf("%s ready%0d", tag, i), 32'(mon_ready), 32'd0);
            if (mon_sen) en_cnt++;
        end
        check({tag, " ser_en edges"}, 32'(en_cnt), 32'(DW));
    endtask

    task automatic send(input logic sel, input logic [DW-1:0] d, input logic [4:0] len,
                        input logic [15:0] bits, input string tag);
        push_frame(len, bits);
        accept(sel, d, tag);
        check_frame(tag, int'(len));
        @(negedge clk);
        check({tag, " idle tx_out"}, 32'(mon_tx), 32'd1);
        check({tag, " idle ready"}, 32'(mon_ready), 32'd1);
    endtask

    initial begin
        int t;
        rst       = 1'b0;
        va        = 1'b0;
        vb        = 1'b0;
        da        = '0;
        db        = '0;
        inj_early = 1'b0;
        fake_done = 1'b0;
        cur_sel   = 1'b0;

        vecs[0] = '{sel: 1'b0, data: 8'hA5, len: 5'd11, bits: 16'b01010010101};
        vecs[1] = '{sel: 1'b0, data: 8'h01, len: 5'd11, bits: 16'b01000000011};
        vecs[2] = '{sel: 1'b0, data: 8'h80, len: 5'd11, bits: 16'b00000000111};
        vecs[3] = '{sel: 1'b1, data: 8'h07, len: 5'd12, bits: 16'b011100000011};
        vecs[4] = '{sel: 1'b1, data: 8'h80, len: 5'd12, bits: 16'b000000001011};
        vecs[5] = '{sel: 1'b1, data: 8'h55, len: 5'd12, bits: 16'b010101010111};

        // ---- reset and idle ------------------------------------------------
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst tx_a",    32'(tx_a),    32'd1);
        check("rst ready_a", 32'(ready_a), 32'd1);
        check("rst sen_a",   32'(sen_a),   32'd0);
        check("rst busy_a",  32'(busy_a),  32'd0);
        check("rst err_a",   32'(err_a),   32'd0);
        check("rst pd_a",    32'(pd_a),    32'd0);
        check("rst tx_b",    32'(tx_b),    32'd1);
        check("rst ready_b", 32'(ready_b), 32'd1);
        check("rst sen_b",   32'(sen_b),   32'd0);
        check("rst busy_b",  32'(busy_b),  32'd0);
        check("rst err_b",   32'(err_b),   32'd0);

        // ---- table-driven frames ------------------------------------------
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].sel, vecs[i].data, vecs[i].len, vecs[i].bits,
                 $sformatf("vec%0d", i));
        end

        // ---- back-to-back with tx_valid held -------------------------------
        push_frame(5'd11, 16'b00000000001);
        push_frame(5'd11, 16'b01111111101);
        cur_sel = 1'b0;
        @(negedge clk);
        check("b2b ready", 32'(ready_a), 32'd1);
        va = 1'b1;
        da = 8'h00;
        @(posedge clk);
        #1;
        da = 8'hFF;  // presented while busy: must wait for the next IDLE
        check_frame("b2b0", 11);
        @(negedge clk);
        check("b2b gap tx_out", 32'(tx_a),   32'd1);
        check("b2b gap busy",   32'(busy_a), 32'd0);
        @(posedge clk);
        #1;
        va = 1'b0;
        check_frame("b2b1", 11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("b2b after busy%0d", i), 32'(busy_a), 32'd0);
        end

        // ---- reset during data bit 3 ---------------------------------------
        accept(1'b0, 8'hA5, "rstmid");
        repeat (5) @(negedge clk);  // start bit, data bits 0..3
        check("rstmid busy", 32'(busy_a), 32'd1);
        rst = 1'b0;
        #1;
        check("rstmid tx_out", 32'(tx_a),    32'd1);
        check("rstmid ser_en", 32'(sen_a),   32'd0);
        check("rstmid busy0",  32'(busy_a),  32'd0);
        check("rstmid ready",  32'(ready_a), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        send(1'b0, 8'h3C, 5'd11, 16'b00011110001, "after_rst");

        check("no err a", 32'(err_a), 32'd0);
        check("no err b", 32'(err_b), 32'd0);

        // ---- early ser_done -------------------------------------------------
        inj_early = 1'b1;
        accept(1'b0, 8'h5A, "early");
        repeat (7) @(posedge clk);  // up to the edge that starts data bit 6
        #1;
        fake_done = 1'b1;
        @(posedge clk);
        #1;
        fake_done = 1'b0;
        @(negedge clk);
        check("early err set", 32'(err_a), 32'd1);
        t = 0;
        while (busy_a && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("early returns idle", 32'(busy_a), 32'd0);
        inj_early = 1'b0;
        repeat (3) @(negedge clk);
        check("early err sticky", 32'(err_a), 32'd1);
        send(1'b0, 8'h01, 5'd11, 16'b01000000011, "post_err");
        check("err still sticky", 32'(err_a), 32'd1);

        rst = 1'b0;
        #1;
        check("reset clears err", 32'(err_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_ctrl
